// File: rtl/mandelbrot_engine.sv
// ---------------------------------------------------------------------------
// mandelbrot_engine
//
// Multi-lane escape-time iteration engine for Mandelbrot and Julia sets.
// Points arrive on a valid/ready stream and are given to the lowest-indexed
// idle lane. Each lane runs z <- z^2 + c in signed fixed point until |z|^2
// exceeds the escape radius or the per-point iteration limit is reached.
// Lanes run concurrently. Tagged results leave through a single registered
// valid/ready output stage, so they can come back out of order. Finished
// lanes share that stage through a round-robin arbiter.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   in_valid_i/ready_o   input handshake; ready while any lane is idle
//   in_x_i, in_y_i       point, signed Q(INTEGER_BITS).(FRACTIONAL_BITS)
//   in_tag_i             caller tag, returned with the result
//   julia_i              0: z0 = c = point; 1: z0 = point, c = (c_re, c_im)
//   c_re_i, c_im_i       Julia constant
//   max_iter_i           iteration limit for this point
//   out_valid_o/ready_i  output handshake
//   out_iter_o           iteration count k at termination
//   out_escaped_o        1 = escaped, 0 = stopped at the limit
//   out_tag_o            tag of the finished point
//   busy_o               any lane active or a result pending
//
// Lane FSM:
//   state | meaning
//   IDLE  | lane empty, can take a new point
//   RUN   | one escape/limit check and one z update per cycle
//   DONE  | result held, waiting for the output register
// ---------------------------------------------------------------------------
module mandelbrot_engine #(
    parameter int  INTEGER_BITS     = 8,
    parameter int  FRACTIONAL_BITS  = 24,
    parameter int  MAX_ITER_WIDTH   = 16,
    parameter int  NUM_LANES        = 4,
    parameter int  TAG_WIDTH        = 8,
    parameter int  ESCAPE_RADIUS_SQ = 4,
    localparam int W                = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [W-1:0]              in_x_i,
    input  logic [W-1:0]              in_y_i,
    input  logic [TAG_WIDTH-1:0]      in_tag_i,
    input  logic                      julia_i,
    input  logic [W-1:0]              c_re_i,
    input  logic [W-1:0]              c_im_i,
    input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [MAX_ITER_WIDTH-1:0] out_iter_o,
    output logic                      out_escaped_o,
    output logic [TAG_WIDTH-1:0]      out_tag_o,
    output logic                      busy_o
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // |z|^2 is kept one bit wider than W, so this threshold and the sum
    // cannot wrap even when both squares are close to full scale.
    localparam logic [W:0] ESC_THRESH = (W+1)'(ESCAPE_RADIUS_SQ) << FRACTIONAL_BITS;

    // Per-lane status, exported from the generate block.
    logic [NUM_LANES-1:0]      lane_idle;
    logic [NUM_LANES-1:0]      lane_done;
    logic [NUM_LANES-1:0]      lane_esc;
    logic [MAX_ITER_WIDTH-1:0] lane_k   [NUM_LANES];
    logic [TAG_WIDTH-1:0]      lane_tag [NUM_LANES];

    logic [NUM_LANES-1:0]      accept_vec;
    logic [NUM_LANES-1:0]      release_vec;

    logic [LW-1:0]             rr_ptr;
    logic [LW-1:0]             sel_idx;
    logic [LW-1:0]             next_ptr;
    logic                      sel_found;
    logic                      load_fire;
    logic [2*NUM_LANES-1:0]    done2;
    logic [NUM_LANES-1:0]      done_rot;

    // Ready depends only on registered lane states. A lane released by the
    // arbiter this cycle shows up as idle in the next cycle.
    assign in_ready_o = |lane_idle;
    assign busy_o     = ~(&lane_idle) | out_valid_o;

    // Lowest-indexed idle lane takes the incoming point.
    always_comb begin
        logic found;
        found      = 1'b0;
        accept_vec = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (in_valid_i && lane_idle[i] && !found) begin
                accept_vec[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Round-robin pick among DONE lanes. The done vector is rotated so that
    // rr_ptr becomes bit 0. The first set bit is then turned back into a
    // lane index.
    assign done2    = {lane_done, lane_done};
    assign done_rot = NUM_LANES'(done2 >> rr_ptr);

    always_comb begin
        int rot_idx;
        rot_idx   = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!sel_found && done_rot[i]) begin
                sel_found = 1'b1;
                rot_idx   = int'(rr_ptr) + i;
                if (rot_idx >= NUM_LANES) begin
                    rot_idx = rot_idx - NUM_LANES;
                end
                sel_idx   = LW'(rot_idx);
            end
        end
    end

    assign next_ptr  = (sel_idx == LW'(NUM_LANES - 1)) ? '0 : sel_idx + LW'(1);

    // The output register loads when it is empty or is being drained.
    assign load_fire = sel_found && (!out_valid_o || out_ready_i);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [1:0]                state_q;
        logic signed [W-1:0]       zx_q;
        logic signed [W-1:0]       zy_q;
        logic signed [W-1:0]       cx_q;
        logic signed [W-1:0]       cy_q;
        logic [MAX_ITER_WIDTH-1:0] k_q;
        logic [MAX_ITER_WIDTH-1:0] lim_q;
        logic [TAG_WIDTH-1:0]      tag_q;
        logic                      esc_q;

        logic signed [2*W-1:0]     ext_x;
        logic signed [2*W-1:0]     ext_y;
        logic signed [2*W-1:0]     p_xx;
        logic signed [2*W-1:0]     p_yy;
        logic signed [2*W-1:0]     p_xy;
        logic signed [W-1:0]       sq_x;
        logic signed [W-1:0]       sq_y;
        logic signed [W-1:0]       xy;
        logic signed [W-1:0]       xy2;
        logic signed [W-1:0]       nx;
        logic signed [W-1:0]       ny;
        logic [W:0]                mag;
        logic                      escape;
        logic                      at_limit;

        // Full-width signed products. The arithmetic right shift floors the
        // result, and only the low W bits are kept.
        assign ext_x = $signed({{W{zx_q[W-1]}}, zx_q});
        assign ext_y = $signed({{W{zy_q[W-1]}}, zy_q});
        assign p_xx  = ext_x * ext_x;
        assign p_yy  = ext_y * ext_y;
        assign p_xy  = ext_x * ext_y;
        assign sq_x  = W'(p_xx >>> FRACTIONAL_BITS);
        assign sq_y  = W'(p_yy >>> FRACTIONAL_BITS);
        assign xy    = W'(p_xy >>> FRACTIONAL_BITS);
        assign xy2   = xy <<< 1;

        assign nx    = sq_x - sq_y + cx_q;
        assign ny    = xy2 + cy_q;

        // Both squares are non-negative within the input range, so the sum
        // is taken unsigned in W+1 bits.
        assign mag      = {1'b0, sq_x} + {1'b0, sq_y};
        assign escape   = mag > ESC_THRESH;
        assign at_limit = (k_q == lim_q);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= S_IDLE;
                zx_q    <= '0;
                zy_q    <= '0;
                cx_q    <= '0;
                cy_q    <= '0;
                k_q     <= '0;
                lim_q   <= '0;
                tag_q   <= '0;
                esc_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept_vec[g]) begin
                            state_q <= S_RUN;
                            zx_q    <= in_x_i;
                            zy_q    <= in_y_i;
                            cx_q    <= julia_i ? c_re_i : in_x_i;
                            cy_q    <= julia_i ? c_im_i : in_y_i;
                            k_q     <= '0;
                            lim_q   <= max_iter_i;
                            tag_q   <= in_tag_i;
                            esc_q   <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        // Escape wins over the limit, so max_iter = 0 still
                        // reports escape for a point that starts outside.
                        if (escape) begin
                            state_q <= S_DONE;
                            esc_q   <= 1'b1;
                        end else if (at_limit) begin
                            state_q <= S_DONE;
                            esc_q   <= 1'b0;
                        end else begin
                            zx_q <= nx;
                            zy_q <= ny;
                            k_q  <= k_q + MAX_ITER_WIDTH'(1);
                        end
                    end
                    S_DONE: begin
                        if (release_vec[g]) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end

        assign lane_idle[g]   = (state_q == S_IDLE);
        assign lane_done[g]   = (state_q == S_DONE);
        assign lane_esc[g]    = esc_q;
        assign lane_k[g]      = k_q;
        assign lane_tag[g]    = tag_q;
        assign release_vec[g] = load_fire && (sel_idx == LW'(g));
    end

    // Output register and round-robin pointer. While a result is stalled,
    // nothing in this block changes, so the outputs stay stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o   <= 1'b0;
            out_iter_o    <= '0;
            out_escaped_o <= 1'b0;
            out_tag_o     <= '0;
            rr_ptr        <= '0;
        end else if (load_fire) begin
            out_valid_o   <= 1'b1;
            out_iter_o    <= lane_k[sel_idx];
            out_escaped_o <= lane_esc[sel_idx];
            out_tag_o     <= lane_tag[sel_idx];
            rr_ptr        <= next_ptr;
        end else if (out_ready_i) begin
            out_valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mandelbrot_engine.sv
`timescale 1ns/1ps
module tb_mandelbrot_engine;

    localparam int IB  = 8;
    localparam int FB  = 24;
    localparam int W   = IB + FB;
    localparam int MIW = 16;
    localparam int NL  = 4;
    localparam int TW  = 8;
    localparam int ERS = 4;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [W-1:0]   in_x_i;
    logic [W-1:0]   in_y_i;
    logic [TW-1:0]  in_tag_i;
    logic           julia_i;
    logic [W-1:0]   c_re_i;
    logic [W-1:0]   c_im_i;
    logic [MIW-1:0] max_iter_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [MIW-1:0] out_iter_o;
    logic           out_escaped_o;
    logic [TW-1:0]  out_tag_o;
    logic           busy_o;

    mandelbrot_engine #(
        .INTEGER_BITS    (IB),
        .FRACTIONAL_BITS (FB),
        .MAX_ITER_WIDTH  (MIW),
        .NUM_LANES       (NL),
        .TAG_WIDTH       (TW),
        .ESCAPE_RADIUS_SQ(ERS)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_x_i       (in_x_i),
        .in_y_i       (in_y_i),
        .in_tag_i     (in_tag_i),
        .julia_i      (julia_i),
        .c_re_i       (c_re_i),
        .c_im_i       (c_im_i),
        .max_iter_i   (max_iter_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_iter_o   (out_iter_o),
        .out_escaped_o(out_escaped_o),
        .out_tag_o    (out_tag_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [TW-1:0] tag;
        int            iter;
        bit            esc;
        longint        acc;
        bit            chk_lat;
    } exp_t;

    exp_t      sb[$];
    logic [TW-1:0] got[$];
    longint    cyc = 0;
    longint    acc_cyc [256];
    longint    out_cyc [256];
    int        n_tests = 0;
    int        n_fail  = 0;
    bit        rand_ready = 1'b0;

    bit            hold_chk = 1'b0;
    logic [MIW-1:0] h_iter;
    logic          h_esc;
    logic [TW-1:0] h_tag;
    int            mon_idx;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint t32(input longint v);
        return longint'(int'(v));
    endfunction

    // Reference: escape-time iteration computed directly with 64-bit
    // integers, following the fixed-point rules of the block.
    function automatic void ref_point(input int x, input int y, input bit jul,
                                      input int cre, input int cim, input int mi,
                                      output int k, output bit esc);
        longint zx, zy, cx, cy, xx, yy, xy;
        zx = x;
        zy = y;
        cx = jul ? longint'(cre) : longint'(x);
        cy = jul ? longint'(cim) : longint'(y);
        k = 0;
        esc = 1'b0;
        for (int step = 0; step <= mi; step++) begin
            xx = t32((zx * zx) >>> FB);
            yy = t32((zy * zy) >>> FB);
            if (xx + yy > (longint'(ERS) << FB)) begin
                k = step; esc = 1'b1; return;
            end
            if (step == mi) begin
                k = step; esc = 1'b0; return;
            end
            xy = t32((zx * zy) >>> FB);
            zx = t32(xx - yy + cx);
            zy = t32(t32(xy * 2) + cy);
        end
    endfunction

    function automatic int rnd_fx();
        return int'($urandom_range(0, 32'h0400_0000)) - (2 << FB);
    endfunction

    task automatic send_point(input int x, input int y, input bit jul, input int cre,
                              input int cim, input int mi, input logic [TW-1:0] tag,
                              input bit chk_lat);
        int   k;
        bit   esc;
        int   n;
        exp_t e;
        ref_point(x, y, jul, cre, cim, mi, k, esc);
        @(negedge clk_i);
        in_x_i     = x;
        in_y_i     = y;
        julia_i    = jul;
        c_re_i     = cre;
        c_im_i     = cim;
        max_iter_i = MIW'(mi);
        in_tag_i   = tag;
        in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready_o) begin
            check("accept_timeout", 0, 1);
            in_valid_i = 1'b0;
            return;
        end
        e.tag = tag; e.iter = k; e.esc = esc; e.acc = cyc; e.chk_lat = chk_lat;
        sb.push_back(e);
        acc_cyc[tag] = cyc;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_outstanding", sb.size(), 0);
        sb.delete();
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk_i);
        #1;
        out_ready_i = v;
    endtask

    always @(posedge clk_i) begin
        if (rand_ready) begin
            #1;
            out_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks stalled outputs stay frozen and scores every transfer
    // against the outstanding expectations, matched by tag.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_valid", out_valid_o, 1);
                check("hold_iter", out_iter_o, h_iter);
                check("hold_escaped", out_escaped_o, h_esc);
                check("hold_tag", out_tag_o, h_tag);
            end
            hold_chk = 1'b0;
            if (out_valid_o && out_ready_i) begin
                mon_idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (mon_idx < 0 && sb[i].tag == out_tag_o) mon_idx = i;
                end
                if (mon_idx < 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: tag=%0d is not outstanding, required none", out_tag_o);
                end else begin
                    check($sformatf("iter_tag%0d", out_tag_o), out_iter_o, sb[mon_idx].iter);
                    check($sformatf("escaped_tag%0d", out_tag_o), out_escaped_o, sb[mon_idx].esc);
                    if (sb[mon_idx].chk_lat)
                        check($sformatf("latency_tag%0d", out_tag_o), cyc - sb[mon_idx].acc,
                              3 + sb[mon_idx].iter);
                    out_cyc[out_tag_o] = cyc;
                    got.push_back(out_tag_o);
                    sb.delete(mon_idx);
                end
            end else if (out_valid_o) begin
                hold_chk = 1'b1;
                h_iter   = out_iter_o;
                h_esc    = out_escaped_o;
                h_tag    = out_tag_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int n;
        int stale;
        for (int i = 0; i < 256; i++) begin
            acc_cyc[i] = -1;
            out_cyc[i] = -1;
        end
        rst_ni = 1'b0; in_valid_i = 1'b0; in_x_i = '0; in_y_i = '0; in_tag_i = '0;
        julia_i = 1'b0; c_re_i = '0; c_im_i = '0; max_iter_i = '0; out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_iter", out_iter_o, 0);
        check("rst_out_escaped", out_escaped_o, 0);
        check("rst_out_tag", out_tag_o, 0);
        check("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_reset", in_ready_o, 1);
        check("idle_busy", busy_o, 0);

        // Directed points, one at a time, with latency checks.
        send_point(0, 0, 0, 0, 0, 100, 8'h05, 1);            wait_drain(300);
        send_point(3 << FB, 0, 0, 0, 0, 50, 8'h06, 1);       wait_drain(50);
        send_point(1 << FB, 0, 0, 0, 0, 50, 8'h07, 1);       wait_drain(50);
        send_point(0, 0, 0, 0, 0, 0, 8'h08, 1);              wait_drain(50);
        send_point(3 << (FB - 1), 0, 1, 0, 0, 20, 8'h09, 1); wait_drain(50);
        send_point(1 << (FB - 1), 0, 1, 0, 0, 20, 8'h0A, 1); wait_drain(100);

        // All lanes busy: a fifth point stalls until a lane is released.
        for (int t = 1; t <= 4; t++) send_point(0, 0, 0, 0, 0, 1000, TW'(t), 0);
        @(negedge clk_i);
        check("ready_low_when_full", in_ready_o, 0);
        check("busy_when_full", busy_o, 1);
        send_point(3 << FB, 0, 0, 0, 0, 50, 8'h05, 0);
        check("fifth_accept_when_lane_frees", acc_cyc[5], out_cyc[1]);
        wait_drain(100);

        // Reset with three lanes running and a result pending.
        set_ready(1'b0);
        send_point(3 << FB, 0, 0, 0, 0, 50, 8'h30, 0);
        for (int t = 0; t < 3; t++) send_point(0, 0, 0, 0, 0, 1000, TW'(8'h31 + t), 0);
        repeat (3) @(negedge clk_i);
        check("pending_before_reset", out_valid_o, 1);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("valid_in_reset", out_valid_o, 0);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        sb.delete();
        @(negedge clk_i);
        check("post_reset_valid", out_valid_o, 0);
        check("post_reset_busy", busy_o, 0);
        check("post_reset_ready", in_ready_o, 1);
        set_ready(1'b1);
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (out_valid_o) stale++;
        end
        check("no_stale_after_reset", stale, 0);

        // Two lanes finish together under backpressure; round-robin from
        // lane 0 after reset gives lane 0 then lane 1, one per cycle.
        set_ready(1'b0);
        got.delete();
        send_point(2 << FB, 0, 0, 0, 0, 20, 8'hA1, 0);
        send_point(3 << FB, 0, 0, 0, 0, 20, 8'hB2, 0);
        n = 0;
        while (!out_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("pair_valid", out_valid_o, 1);
        repeat (10) @(negedge clk_i);
        check("busy_while_stalled", busy_o, 1);
        set_ready(1'b1);
        wait_drain(20);
        check("pair_count", got.size(), 2);
        if (got.size() == 2) begin
            check("pair_first_tag", got[0], 8'hA1);
            check("pair_second_tag", got[1], 8'hB2);
        end
        check("pair_back_to_back", out_cyc[8'hB2] - out_cyc[8'hA1], 1);

        // Random Mandelbrot/Julia points with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            send_point(rnd_fx(), rnd_fx(), bit'($urandom_range(0, 1)), rnd_fx(), rnd_fx(),
                       int'($urandom_range(0, 40)), TW'(8'h40 + i), 0);
        end
        wait_drain(2000);
        rand_ready = 1'b0;
        set_ready(1'b1);
        repeat (5) @(negedge clk_i);
        check("final_busy", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
